stream_mem_loader: RTL and testbench

- Avalon-MM write master that sits directly upstream of the single-port on-chip memory (512 x 32, byte-enabled).
- Accepts a byte stream from the boot/flash path using a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and writes them to consecutive word addresses from a programmed base.
- Reports busy/done/overflow to the control CPU.

---
 rtl/stream_mem_loader_pkg.sv | 17 +
 rtl/stream_mem_loader_byte_word_packer.sv | 32 +++
 rtl/stream_mem_loader.sv | 136 +++++++++++++
 tb/tb_stream_mem_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mem_loader_pkg.sv
// Shared types and constants for stream_mem_loader and its byte packer.
package stream_mem_loader_pkg;

  localparam int unsigned ADDR_W_DEF     = 9;
  localparam int unsigned LEN_W_DEF      = 11;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/stream_mem_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: lane counter, pack register and byteenable.
module byte_word_packer
  import stream_mem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [7:0]                data,
  output logic [LANE_W-1:0]         lane,
  output logic [WORD_W-1:0]         pack,
  output logic [BYTES_PER_WORD-1:0] be
);

  // Clearing zeroes the whole word so lanes never loaded read back as 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane <= '0;
      pack <= '0;
      be   <= '0;
    end else if (clear) begin
      lane <= '0;
      pack <= '0;
      be   <= '0;
    end else if (load) begin
      pack[8*lane +: 8] <= data;
      be[lane]          <= 1'b1;
      lane              <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/stream_mem_loader.sv
// Byte-stream to 32-bit Avalon-MM write master for the on-chip boot memory.
// Optional running checksum output enabled by STREAM_MEM_LOADER_CHECKSUM_EN.
module stream_mem_loader
  import stream_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          length,
  input  logic                      s_valid,
  input  logic [7:0]                s_data,
  output logic                      s_ready,
  input  logic                      hold,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [BYTES_PER_WORD-1:0] mem_byteenable,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic [WORD_W-1:0]         mem_writedata,
  output logic                      mem_clken,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]         checksum
`endif
);

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         addr, addr_nxt;
  logic [LEN_W-1:0]          remaining, remaining_nxt;
  logic                      done_nxt, overflow_nxt;
  logic                      start_acc, accept, wr_eff, pk_clear;
  logic [LANE_W-1:0]         lane;
  logic [WORD_W-1:0]         pack;
  logic [BYTES_PER_WORD-1:0] be;

  assign start_acc = start & ((state == IDLE) | (state == DONE));
  assign accept    = s_valid & s_ready;
  assign wr_eff    = (state == WRITE) & ~hold;

  assign mem_clken      = ~hold;
  assign mem_address    = addr;
  assign mem_byteenable = be;
  assign mem_writedata  = pack;

  byte_word_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pk_clear),
    .load    (accept),
    .data    (s_data),
    .lane    (lane),
    .pack    (pack),
    .be      (be)
  );

  // Next-state and counter/flag update logic.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    done_nxt      = done;
    overflow_nxt  = overflow;
    pk_clear      = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start_acc) begin
          addr_nxt      = base_addr;
          remaining_nxt = length;
          done_nxt      = 1'b0;
          overflow_nxt  = 1'b0;
          pk_clear      = 1'b1;
          state_nxt     = (length == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          remaining_nxt = remaining - LEN_W'(1);
          if ((lane == LANE_W'(BYTES_PER_WORD - 1)) || (remaining == LEN_W'(1)))
            state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!hold) begin
          addr_nxt = addr + ADDR_W'(1);
          if (addr == '1) overflow_nxt = 1'b1;
          pk_clear  = 1'b1;
          state_nxt = (remaining == '0) ? DONE : COLLECT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == DONE) done_nxt = 1'b1;
  end

  // State, counters and registered status/strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
      s_ready        <= 1'b0;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      remaining      <= remaining_nxt;
      done           <= done_nxt;
      overflow       <= overflow_nxt;
      busy           <= (state_nxt == COLLECT) || (state_nxt == WRITE);
      s_ready        <= (state_nxt == COLLECT);
      mem_write      <= (state_nxt == WRITE);
      mem_chipselect <= (state_nxt == WRITE);
    end
  end

`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
  // Running sum of effectively written words; disabled lanes are already zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (wr_eff)    checksum <= checksum + pack;
  end
`endif

endmodule

// File: tb/tb_stream_mem_loader.sv
// Randomized self-checking bench for stream_mem_loader against a word-list model.
// Checksum checks are included when STREAM_MEM_LOADER_CHECKSUM_EN is defined.
module tb_stream_mem_loader;

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          hold;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  bytes_q[$];
  logic [8:0]  cap_a[$];
  logic [31:0] cap_d[$];
  logic [3:0]  cap_be[$];
  int          cap_cyc[$];
  int          strobe_cnt;
  logic [8:0]  exp_a[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_be[$];
  logic        exp_ovf;
  logic [31:0] exp_sum;

  always #5 clk = ~clk;

  stream_mem_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .hold           (hold),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  // Reference: split the byte list into 4-byte little-endian words at consecutive addresses.
  task automatic build_model(input int base, input int n);
    exp_a.delete(); exp_d.delete(); exp_be.delete();
    exp_ovf = 1'b0;
    exp_sum = '0;
    for (int w = 0; w < (n + 3) / 4; w++) begin
      int a;
      logic [31:0] d;
      logic [3:0] b;
      a = (base + w) % 512;
      d = '0;
      b = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) begin
          d = d | (32'(bytes_q[4 * w + k]) << (8 * k));
          b = b | (4'b0001 << k);
        end
      if (a == 511) exp_ovf = 1'b1;
      exp_a.push_back(9'(a));
      exp_d.push_back(d);
      exp_be.push_back(b);
      exp_sum = exp_sum + d;
    end
  endtask

  // Drive one transfer with random valid gaps / hold, capturing effective writes.
  task automatic run_xfer(input int base, input int n, input int hold_pct, input int gap_pct,
                          input bit noise, output bit to, output int done_cyc);
    int idx = 0;
    cap_a.delete(); cap_d.delete(); cap_be.delete(); cap_cyc.delete();
    strobe_cnt = 0;
    to = 1'b1;
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); length = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (idx < n && int'($urandom_range(99)) >= gap_pct) begin
        s_valid = 1'b1; s_data = bytes_q[idx];
      end else begin
        s_valid = 1'b0; s_data = 8'($urandom);
      end
      hold = (int'($urandom_range(99)) < hold_pct);
      if (noise && idx < n && $urandom_range(3) == 0) begin
        start = 1'b1; base_addr = AW'($urandom); length = LW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      if (mem_write && mem_chipselect) begin
        strobe_cnt++;
        if (mem_clken) begin
          cap_a.push_back(mem_address); cap_d.push_back(mem_writedata);
          cap_be.push_back(mem_byteenable); cap_cyc.push_back(cyc);
        end
      end
      if (done) begin
        to = 1'b0; done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; hold = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    s_valid = 1'b0; s_data = '0; hold = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, overflow, s_ready, mem_write, mem_chipselect, mem_byteenable,
         mem_address, mem_writedata} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", {busy, done, overflow, s_ready,
        mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata});
    end
    hold = 1'b1; #1;
    n_cmp++;
    if (mem_clken !== 1'b0) begin n_err++; $display("FAIL reset_clken: got %b required 0", mem_clken); end
    hold = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit to; int dc;
    bytes_q.delete();
    for (int i = 1; i <= 8; i++) bytes_q.push_back(8'(i));
    run_xfer(32'h010, 8, 0, 0, 1'b0, to, dc);
    n_cmp++;
    if (to || cap_a.size() != 2) begin
      n_err++; $display("FAIL basic_count: got to=%0b writes=%0d required to=0 writes=2", to, cap_a.size());
    end else begin
      n_cmp++;
      if ({cap_a[0], cap_d[0], cap_be[0], cap_a[1], cap_d[1], cap_be[1]} !==
          {9'h010, 32'h04030201, 4'hF, 9'h011, 32'h08070605, 4'hF}) begin
        n_err++; $display("FAIL basic_words: got %h/%h/%h %h/%h/%h", cap_a[0], cap_d[0], cap_be[0],
                          cap_a[1], cap_d[1], cap_be[1]);
      end
      n_cmp++;
      if (cap_cyc[0] != 4 || cap_cyc[1] != 9 || dc != 10) begin
        n_err++; $display("FAIL basic_timing: got wr=%0d,%0d done=%0d required 4,9,10",
                          cap_cyc[0], cap_cyc[1], dc);
      end
    end
    n_cmp++;
    if ({busy, done, overflow} !== 3'b010) begin
      n_err++; $display("FAIL basic_flags: got busy/done/ovf=%b required 010", {busy, done, overflow});
    end
`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 32'h0C0A0806) begin
      n_err++; $display("FAIL basic_checksum: got %h required 0c0a0806", checksum);
    end
`endif
  endtask

  task automatic test_partial();
    bit to; int dc; int base;
    base = int'($urandom_range(0, 500));
    bytes_q.delete();
    for (int i = 0; i < 6; i++) bytes_q.push_back(8'(8'hA0 + i));
    run_xfer(base, 6, 0, 20, 1'b0, to, dc);
    n_cmp++;
    if (to || cap_a.size() != 2) begin
      n_err++; $display("FAIL partial_count: got to=%0b writes=%0d required to=0 writes=2", to, cap_a.size());
    end else begin
      n_cmp++;
      if ({cap_a[1], cap_d[1], cap_be[1]} !== {9'(base + 1), 32'h0000A5A4, 4'b0011}) begin
        n_err++; $display("FAIL partial_word: got %h/%h/%h required %h/0000a5a4/3",
                          cap_a[1], cap_d[1], cap_be[1], 9'(base + 1));
      end
    end
  endtask

  task automatic test_wrap();
    bit to; int dc;
    bytes_q.delete();
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
    run_xfer(32'h1FF, 8, 0, 0, 1'b0, to, dc);
    n_cmp++;
    if (to || cap_a.size() != 2 || cap_a[0] !== 9'h1FF || cap_a[1] !== 9'h000) begin
      n_err++; $display("FAIL wrap_addr: got to=%0b writes=%0d required 1ff then 000", to, cap_a.size());
    end
    n_cmp++;
    if ({overflow, done} !== 2'b11) begin
      n_err++; $display("FAIL wrap_flags: got ovf/done=%b required 11", {overflow, done});
    end
  endtask

  task automatic test_hold();
    int strobes = 0, writes = 0, rdy_bad = 0, data_bad = 0;
    bit seen = 1'b0;
    bytes_q.delete();
    bytes_q.push_back(8'h11); bytes_q.push_back(8'h22);
    bytes_q.push_back(8'h33); bytes_q.push_back(8'h44);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h020; length = 11'd4;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      s_data = (c < 4) ? bytes_q[c] : 8'hEE;
      hold = (c >= 4 && c <= 6);
      @(negedge clk);
      if (mem_write && mem_chipselect) begin
        strobes++;
        if (s_ready) rdy_bad++;
        if ({mem_address, mem_writedata, mem_byteenable} !== {9'h020, 32'h44332211, 4'hF}) data_bad++;
        if (mem_clken) writes++;
      end
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    s_valid = 1'b0; hold = 1'b0;
    n_cmp++;
    if (strobes != 4 || writes != 1) begin
      n_err++; $display("FAIL hold_strobe: got strobes=%0d writes=%0d required 4 and 1", strobes, writes);
    end
    n_cmp++;
    if (rdy_bad != 0 || data_bad != 0) begin
      n_err++; $display("FAIL hold_stable: got ready_hi=%0d data_changed=%0d required 0 0", rdy_bad, data_bad);
    end
    n_cmp++;
    if ({seen, overflow} !== 2'b10) begin
      n_err++; $display("FAIL hold_done: got done/ovf=%b required 10", {seen, overflow});
    end
  endtask

  task automatic test_zero_len();
    bit to; int dc;
    bytes_q.delete();
    run_xfer(32'h0AA, 0, 0, 0, 1'b0, to, dc);
    n_cmp++;
    if (to || dc != 0 || strobe_cnt != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_len: got to=%0b done_cyc=%0d strobes=%0d busy=%b required 0 0 0 0",
                        to, dc, strobe_cnt, busy);
    end
  endtask

  task automatic test_start_busy();
    for (int it = 0; it < 3; it++) begin
      bit to; int dc; int base, n;
      base = int'($urandom_range(0, 511));
      n = int'($urandom_range(5, 30));
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      build_model(base, n);
      run_xfer(base, n, 20, 20, 1'b1, to, dc);
      n_cmp++;
      if (to || cap_a.size() != exp_a.size()) begin
        n_err++; $display("FAIL busy_start_count: got to=%0b writes=%0d required %0d", to, cap_a.size(), exp_a.size());
      end else begin
        for (int w = 0; w < exp_a.size(); w++) begin
          n_cmp++;
          if ({cap_a[w], cap_d[w], cap_be[w]} !== {exp_a[w], exp_d[w], exp_be[w]}) begin
            n_err++; $display("FAIL busy_start_word%0d: got %h/%h/%h required %h/%h/%h", w,
                              cap_a[w], cap_d[w], cap_be[w], exp_a[w], exp_d[w], exp_be[w]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    bytes_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h050; length = 11'd8;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
    @(posedge clk); #1;
    s_data = 8'h5B;
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, overflow, s_ready, mem_write, mem_chipselect, mem_byteenable,
         mem_address, mem_writedata} !== '0 || mem_clken !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_outputs: got %h clken=%b required 0 clken=1", {busy, done, overflow,
        s_ready, mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata}, mem_clken);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 2) reset_n = 1'b1;
      @(negedge clk);
      if (mem_write || mem_chipselect) strobes++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (strobes != 0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_idle: got strobes=%0d done=%b busy=%b required 0 0 0", strobes, done, busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit to; int dc; int base, n;
      base = (it % 3 == 0) ? 511 - int'($urandom_range(0, 3)) : int'($urandom_range(0, 511));
      n = int'($urandom_range(1, 40));
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      build_model(base, n);
      run_xfer(base, n, 30, 30, 1'b0, to, dc);
      n_cmp++;
      if (to || cap_a.size() != exp_a.size()) begin
        n_err++; $display("FAIL rand%0d_count: got to=%0b writes=%0d required %0d", it, to, cap_a.size(), exp_a.size());
      end else begin
        for (int w = 0; w < exp_a.size(); w++) begin
          n_cmp++;
          if ({cap_a[w], cap_d[w], cap_be[w]} !== {exp_a[w], exp_d[w], exp_be[w]}) begin
            n_err++; $display("FAIL rand%0d_word%0d: got %h/%h/%h required %h/%h/%h", it, w,
                              cap_a[w], cap_d[w], cap_be[w], exp_a[w], exp_d[w], exp_be[w]);
          end
        end
      end
      n_cmp++;
      if ({done, busy, overflow} !== {1'b1, 1'b0, exp_ovf}) begin
        n_err++; $display("FAIL rand%0d_flags: got done/busy/ovf=%b required %b", it,
                          {done, busy, overflow}, {1'b1, 1'b0, exp_ovf});
      end
`ifdef STREAM_MEM_LOADER_CHECKSUM_EN
      n_cmp++;
      if (checksum !== exp_sum) begin
        n_err++; $display("FAIL rand%0d_checksum: got %h required %h", it, checksum, exp_sum);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_wrap();
    test_hold();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
